risc_dmem_arbiter: RTL and testbench

RISC_DMEM_ARBITER -- requirements
Module: risc_dmem_arbiter

---
 rtl/risc_dmem_arbiter_if.sv | 48 ++++
 rtl/risc_dmem_arbiter.sv | 108 ++++++++++
 tb/tb_risc_dmem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/risc_dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory environment.
interface risc_dmem_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [WORD_WIDTH-1:0] m0_addr;
  logic [WORD_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [WORD_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [WORD_WIDTH-1:0] m1_addr;
  logic [WORD_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [WORD_WIDTH-1:0] m1_rdata;

  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [WORD_WIDTH-1:0] mem_data_out;
  logic                  busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_data_out,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_data_in, mem_wr_en, mem_rd_en,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_data_out,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_data_in, mem_wr_en, mem_rd_en,
    input  busy
  );
endinterface

// File: rtl/risc_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// IDLE arbitrates and latches a command, ISSUE drives the memory, RESP returns read data.
module risc_dmem_arbiter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [WORD_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [WORD_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [WORD_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WORD_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  winner;
  logic                  gnt0, gnt1, wr_en, rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    rvalid_d     = 1'b0;
    winner       = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // On a tie the requester that did not win last time goes first.
          winner       = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
          owner_d      = winner;
          last_grant_d = winner;
          cmd_we_d     = winner ? bus.m1_we    : bus.m0_we;
          cmd_addr_d   = winner ? bus.m1_addr  : bus.m0_addr;
          cmd_wdata_d  = winner ? bus.m1_wdata : bus.m0_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wr_en   = cmd_we_q;
        rd_en   = ~cmd_we_q;
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        state_d = cmd_we_q ? IDLE : RESP;
      end
      RESP: begin
        if (owner_q) m1_rdata_d = bus.mem_data_out;
        else         m0_rdata_d = bus.mem_data_out;
        rvalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // owner_q still names the reader while its rvalid pulse is out, even if a new win is latched that cycle.
  assign bus.m0_gnt      = gnt0;
  assign bus.m1_gnt      = gnt1;
  assign bus.m0_rvalid   = rvalid_q & ~owner_q;
  assign bus.m1_rvalid   = rvalid_q & owner_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.mem_addr    = cmd_addr_q;
  assign bus.mem_data_in = cmd_wdata_q;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_rd_en   = rd_en;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_risc_dmem_arbiter.sv
// Directed self-checking bench for risc_dmem_arbiter with a small behavioural data memory.
module tb_risc_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  risc_dmem_arbiter_if #(.WORD_WIDTH(32)) bus ();

  risc_dmem_arbiter #(.WORD_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns read data the cycle after mem_rd_en; two words preloaded while in reset.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 32'hDEADBEEF;
      mem[5] <= 32'hCAFEF00D;
    end else begin
      if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_data_in;
      if (bus.mem_rd_en) bus.mem_data_out <= mem[bus.mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  int ng, both_g, both_v, m0_v, m1_v, bad;
  logic order [0:5];
  logic exp_order [0:5];

  initial begin
    checks = 0; failures = 0;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    exp_order[3] = 1'b1; exp_order[4] = 1'b0; exp_order[5] = 1'b1;
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.mem_data_out = 0;

    // Reset state
    #22;
    chk("rst_busy", bus.busy, 0);
    chk("rst_m0_gnt", bus.m0_gnt, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    chk("rst_m1_rvalid", bus.m1_rvalid, 0);
    nxt(); rst = 1'b0;

    // m0 single read of 0x10
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
    nxt();
    chk("rd_m0_gnt", bus.m0_gnt, 1);
    chk("rd_m1_gnt", bus.m1_gnt, 0);
    chk("rd_rd_en", bus.mem_rd_en, 1);
    chk("rd_wr_en", bus.mem_wr_en, 0);
    chk("rd_addr", bus.mem_addr, 32'h10);
    bus.m0_req = 0;
    nxt();
    chk("rd_busy_resp", bus.busy, 1);
    chk("rd_rvalid_early", bus.m0_rvalid, 0);
    chk("rd_rd_en_resp", bus.mem_rd_en, 0);
    nxt();
    chk("rd_m0_rvalid", bus.m0_rvalid, 1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", bus.m1_rvalid, 0);
    chk("rd_m1_rdata", bus.m1_rdata, 0);
    chk("rd_busy_done", bus.busy, 0);
    nxt();
    chk("rd_rvalid_pulse", bus.m0_rvalid, 0);
    chk("rd_rdata_hold", bus.m0_rdata, 32'hDEADBEEF);

    // m1 write 0x20 <- 0x12345678
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h12345678;
    nxt();
    chk("wr_wr_en", bus.mem_wr_en, 1);
    chk("wr_rd_en", bus.mem_rd_en, 0);
    chk("wr_addr", bus.mem_addr, 32'h20);
    chk("wr_data", bus.mem_data_in, 32'h12345678);
    chk("wr_m1_gnt", bus.m1_gnt, 1);
    chk("wr_m0_gnt", bus.m0_gnt, 0);
    bus.m1_req = 0;
    nxt();
    chk("wr_busy", bus.busy, 0);
    chk("wr_wr_en_off", bus.mem_wr_en, 0);
    chk("wr_m1_rvalid", bus.m1_rvalid, 0);
    chk("wr_m0_rdata_kept", bus.m0_rdata, 32'hDEADBEEF);
    nxt();
    chk("wr_m1_rvalid2", bus.m1_rvalid, 0);

    // Simultaneous reads; m1 changes its address while m0 owns the memory
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h20;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h10;
    nxt();
    chk("tie_m0_gnt", bus.m0_gnt, 1);
    chk("tie_m1_gnt", bus.m1_gnt, 0);
    chk("tie_addr", bus.mem_addr, 32'h20);
    bus.m0_req = 0;
    nxt();
    chk("tie_addr_resp", bus.mem_addr, 32'h20);
    chk("tie_m1_gnt_resp", bus.m1_gnt, 0);
    bus.m1_addr = 32'h14;
    nxt();
    chk("tie_m0_rvalid", bus.m0_rvalid, 1);
    chk("tie_m0_rdata", bus.m0_rdata, 32'h12345678);
    chk("tie_addr_idle", bus.mem_addr, 32'h20);
    chk("tie_m1_gnt_idle", bus.m1_gnt, 0);
    nxt();
    chk("tie_m1_gnt", bus.m1_gnt, 1);
    chk("tie_m1_addr", bus.mem_addr, 32'h14);
    chk("tie_m1_rd_en", bus.mem_rd_en, 1);
    bus.m1_req = 0;
    nxt(); nxt();
    chk("tie_m1_rvalid", bus.m1_rvalid, 1);
    chk("tie_m1_rdata", bus.m1_rdata, 32'hCAFEF00D);
    chk("tie_m0_rdata_kept", bus.m0_rdata, 32'h12345678);
    chk("tie_m0_rvalid_off", bus.m0_rvalid, 0);

    // Both hold req continuously: m0 reads, m1 writes
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h24; bus.m1_wdata = 32'hA5A5A5A5;
    ng = 0; both_g = 0; both_v = 0; m0_v = 0; m1_v = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      nxt();
      if (bus.m0_gnt && bus.m1_gnt) both_g++;
      if (bus.m0_rvalid && bus.m1_rvalid) both_v++;
      if (bus.m0_rvalid) m0_v++;
      if (bus.m1_rvalid) m1_v++;
      if (bus.m0_gnt) begin order[ng] = 1'b0; ng++; end
      else if (bus.m1_gnt) begin order[ng] = 1'b1; ng++; end
      if (ng == 6) begin bus.m0_req = 0; bus.m1_req = 0; end
    end
    bus.m0_req = 0; bus.m1_req = 0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      if (bus.m0_rvalid) m0_v++;
      if (bus.m1_rvalid) m1_v++;
      if (bus.m0_gnt || bus.m1_gnt) both_g++;
    end
    chk("rr_grant_count", ng, 6);
    for (int i = 0; i < 6; i++)
      if (i < ng) chk($sformatf("rr_order_%0d", i), order[i], exp_order[i]);
    chk("rr_both_gnt", both_g, 0);
    chk("rr_both_rvalid", both_v, 0);
    chk("rr_m0_rvalids", m0_v, 3);
    chk("rr_m1_rvalids", m1_v, 0);
    chk("rr_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);

    // Reset pulsed during the RESP cycle of an m0 read
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h14;
    nxt();
    chk("rr_rst_m0_gnt", bus.m0_gnt, 1);
    bus.m0_req = 0;
    nxt();
    chk("rr_rst_in_resp", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_rvalid", bus.m0_rvalid, 0);
    chk("rst_mid_rdata", bus.m0_rdata, 0);
    chk("rst_mid_addr", bus.mem_addr, 0);
    chk("rst_mid_rd_en", bus.mem_rd_en, 0);
    nxt(); nxt();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      if (bus.m0_rvalid || bus.busy || bus.m0_gnt) bad++;
    end
    chk("rst_no_late_pulse", bad, 0);

    // First tie after reset goes to m0, then m1
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h30; bus.m0_wdata = 32'h1;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h34; bus.m1_wdata = 32'h2;
    nxt();
    chk("post_rst_m0_gnt", bus.m0_gnt, 1);
    chk("post_rst_m1_gnt", bus.m1_gnt, 0);
    chk("post_rst_addr", bus.mem_addr, 32'h30);
    bus.m0_req = 0;
    nxt();
    chk("post_rst_idle", bus.busy, 0);
    nxt();
    chk("post_rst_m1_gnt2", bus.m1_gnt, 1);
    chk("post_rst_addr2", bus.mem_addr, 32'h34);
    chk("post_rst_data2", bus.mem_data_in, 32'h2);
    bus.m1_req = 0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
